// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- central sequencer for the 5-stage pipeline.
//
// Merges the stall requests from ID, EX and MEM into one per-stage hold
// vector. Sequences exception and eret flushes and supplies the redirect PC.
// A watchdog forces a recovery flush when the pipeline is held for too long.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous reset, active low
//   stallreq_id   in   ID hold request (load-use hazard)
//   stallreq_ex   in   EX hold request (multi-cycle hi/lo op)
//   stallreq_mem  in   MEM hold request (data memory not ready)
//   excepttype_i  in   exception code from MEM, 0 = none
//   epc_i         in   current CP0 EPC (eret target)
//   stall_o       out  hold: [0] pc [1] if_id [2] id_ex [3] ex_mem [4] mem_wb
//                      [5] reserved, always 0
//   flush_o       out  clear all pipeline registers this cycle
//   new_pc_o      out  redirect target, meaningful only while flush_o=1
//   timeout_o     out  sticky: watchdog has fired since reset
//   stall_cnt_o   out  current consecutive-stall count
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int          WDOG_W     = 8,
    parameter int          WDOG_MAX   = 255,
    parameter logic [31:0] ERET_CODE  = 32'h0000_000e
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic [31:0]       excepttype_i,
    input  logic [31:0]       epc_i,
    output logic [5:0]        stall_o,
    output logic              flush_o,
    output logic [31:0]       new_pc_o,
    output logic              timeout_o,
    output logic [WDOG_W-1:0] stall_cnt_o
);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    localparam logic [WDOG_W-1:0] CNT_MAX = WDOG_W'(WDOG_MAX);

    state_t            state;
    logic [WDOG_W-1:0] stall_cnt;
    logic              any_req;
    logic              wdog_fire;

    assign any_req     = stallreq_id | stallreq_ex | stallreq_mem;
    assign stall_cnt_o = stall_cnt;

    // Watchdog fires only while still in RUN and somebody is still asking to
    // hold; a request that drops on the limit cycle is not a hang.
    assign wdog_fire = rst && (state == RUN) && any_req && (stall_cnt == CNT_MAX);

    // Stall/flush are same-cycle responses. The rst term keeps every
    // combinational output at 0 while reset is held, whatever the inputs do.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned -- that is what keeps this block from inferring latches.
        stall_o  = 6'b000000;
        flush_o  = 1'b0;
        new_pc_o = 32'h0;
        if (rst && state == RUN) begin
            if (wdog_fire) begin
                flush_o  = 1'b1;
                new_pc_o = EXC_VECTOR;
            end else if (excepttype_i == ERET_CODE) begin
                flush_o  = 1'b1;
                new_pc_o = epc_i;
            end else if (excepttype_i != 32'h0) begin
                flush_o  = 1'b1;
                new_pc_o = EXC_VECTOR;
            end else if (stallreq_mem) begin
                stall_o = 6'b011111;
            end else if (stallreq_ex) begin
                stall_o = 6'b001111;
            end else if (stallreq_id) begin
                stall_o = 6'b000111;
            end
        end
    end

    // SQUASH lasts exactly one cycle and ignores all requests: whatever
    // arrives then is residue from the wrong path being cleared.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every register
        // in this block samples pre-edge values regardless of statement order.
        if (!rst) begin
            state     <= RUN;
            stall_cnt <= '0;
            timeout_o <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (flush_o) begin
                        state     <= SQUASH;
                        stall_cnt <= '0;
                        if (wdog_fire) timeout_o <= 1'b1;
                    end else if (stall_o != 6'b000000) begin
                        if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
                    end else begin
                        stall_cnt <= '0;
                    end
                end
                SQUASH: begin
                    state     <= RUN;
                    stall_cnt <= '0;
                end
                default: begin
                    state     <= RUN;
                    stall_cnt <= '0;
                end
            endcase
        end
    end

endmodule
